infer_ctrl: RTL and testbench

Sequencer for the fix8 ReLU inference engine top level. Accepts a classify request and pulses engine reset, then start. Waits for engine done, then scans the 10 output scores through the engine's out_idx/out select port. Computes the signed argmax and returns class plus score on a valid/ready result handshake. Sits between the host/test harness and the engine top level; it does not touch the engine's memory port.

---
 rtl/infer_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_infer_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infer_ctrl.sv
// rtl/infer_ctrl.sv - classify-request sequencer for the fix8 ReLU inference engine
//
// Pulses engine reset then start, waits for engine done, scans NUM_CLASSES
// scores through eng_out_idx and returns the signed argmax (ties keep the
// lowest index) on a valid/ready result handshake.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous active-low reset
//   req_valid, req_ready  classify request handshake (ready only when idle)
//   eng_reset, eng_start  one-cycle pulses to the engine
//   eng_done              engine done level
//   eng_out_idx, eng_out  score select to the engine and the selected score
//   res_valid, res_ready  result handshake
//   res_class, res_score  argmax index and its signed score
//   busy                  high in every state except idle
//   err_timeout           sticky WAIT watchdog flag
//
// Optional feature macro: INFER_TIMEOUT_EN enables the WAIT watchdog
// (TIMEOUT_CYCLES). Without it WAIT waits indefinitely and err_timeout is 0.

module infer_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CLASSES    = 10,
  parameter int IDX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic                  eng_reset,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic [IDX_WIDTH-1:0]  eng_out_idx,
  input  logic [DATA_WIDTH-1:0] eng_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDX_WIDTH-1:0]  res_class,
  output logic [DATA_WIDTH-1:0] res_score,
  output logic                  busy,
  output logic                  err_timeout
);

  if (NUM_CLASSES < 1 || NUM_CLASSES > (1 << IDX_WIDTH)) begin : g_bad_classes
    $error("infer_ctrl: NUM_CLASSES does not fit in IDX_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("infer_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_START, S_WAIT, S_SCAN, S_RESULT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] best_score, best_score_nxt;
  logic [IDX_WIDTH-1:0]  best_idx, best_idx_nxt;
  logic [IDX_WIDTH-1:0]  idx_nxt;
  logic                  eng_reset_nxt, eng_start_nxt;
  logic                  res_valid_nxt, err_nxt;
  logic [IDX_WIDTH-1:0]  res_class_nxt;
  logic [DATA_WIDTH-1:0] res_score_nxt;

  // Running argmax candidate including the score currently on eng_out.
  // Strictly-greater keeps the earlier index on ties.
  logic                  take;
  logic [DATA_WIDTH-1:0] cand_score;
  logic [IDX_WIDTH-1:0]  cand_idx;
  logic                  scan_last;
  logic                  timeout_hit;

  assign take       = $signed(eng_out) > $signed(best_score);
  assign cand_score = take ? eng_out : best_score;
  assign cand_idx   = take ? eng_out_idx : best_idx;
  assign scan_last  = (state == S_SCAN) && (eng_out_idx == LAST_IDX);

`ifdef INFER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles; fires on the TIMEOUT_CYCLES-th WAIT cycle without done.
  assign timeout_hit = (state == S_WAIT) && !eng_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = S_CLR;
      S_CLR:    state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          state_nxt = S_SCAN;
        end else if (timeout_hit) begin
          state_nxt = S_RESULT;
        end
      end
      S_SCAN:   if (scan_last) state_nxt = S_RESULT;
      S_RESULT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and scan datapath.
  // The pulses are decoded from the next state so they are high exactly
  // while the FSM sits in CLR / START.
  always_comb begin
    eng_reset_nxt  = (state_nxt == S_CLR);
    eng_start_nxt  = (state_nxt == S_START);
    idx_nxt        = eng_out_idx;
    best_score_nxt = best_score;
    best_idx_nxt   = best_idx;
    res_valid_nxt  = res_valid;
    res_class_nxt  = res_class;
    res_score_nxt  = res_score;
    err_nxt        = err_timeout;
    case (state)
      S_IDLE: begin
        if (req_valid) err_nxt = 1'b0;
      end
      S_WAIT: begin
        if (eng_done) begin
          idx_nxt        = '0;
          best_score_nxt = SCORE_MIN;
          best_idx_nxt   = '0;
        end else if (timeout_hit) begin
          err_nxt       = 1'b1;
          res_valid_nxt = 1'b1;
          res_class_nxt = '0;
          res_score_nxt = '0;
        end
      end
      S_SCAN: begin
        best_score_nxt = cand_score;
        best_idx_nxt   = cand_idx;
        if (scan_last) begin
          idx_nxt       = '0;
          res_valid_nxt = 1'b1;
          res_class_nxt = cand_idx;
          res_score_nxt = cand_score;
        end else begin
          idx_nxt = eng_out_idx + 1'b1;
        end
      end
      S_RESULT: begin
        if (res_ready) res_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_reset   <= 1'b0;
      eng_start   <= 1'b0;
      eng_out_idx <= '0;
      best_score  <= '0;
      best_idx    <= '0;
      res_valid   <= 1'b0;
      res_class   <= '0;
      res_score   <= '0;
      err_timeout <= 1'b0;
    end else begin
      eng_reset   <= eng_reset_nxt;
      eng_start   <= eng_start_nxt;
      eng_out_idx <= idx_nxt;
      best_score  <= best_score_nxt;
      best_idx    <= best_idx_nxt;
      res_valid   <= res_valid_nxt;
      res_class   <= res_class_nxt;
      res_score   <= res_score_nxt;
      err_timeout <= err_nxt;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_infer_ctrl.sv
// tb/tb_infer_ctrl.sv - self-checking bench for infer_ctrl

module tb_infer_ctrl;

  localparam int DW = 8;
  localparam int NC = 10;
  localparam int IW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          eng_done = 1'b0;
  logic          res_ready = 1'b0;
  logic          req_ready, eng_reset, eng_start, res_valid, busy, err_timeout;
  logic [IW-1:0] eng_out_idx, res_class;
  logic [DW-1:0] eng_out, res_score;

  logic signed [DW-1:0] scores [NC];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  infer_ctrl #(
    .DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_out_idx(eng_out_idx), .eng_out(eng_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_score(res_score),
    .busy(busy), .err_timeout(err_timeout)
  );

  // Engine score port: combinational lookup of the selected score.
  always_comb begin
    eng_out = '0;
    for (int i = 0; i < NC; i++) begin
      if (eng_out_idx == IW'(i)) eng_out = scores[i];
    end
  end

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void argmax(output logic [IW-1:0] c, output logic signed [DW-1:0] s);
    c = '0;
    s = scores[0];
    for (int i = 1; i < NC; i++) begin
      if (scores[i] > s) begin
        s = scores[i];
        c = IW'(i);
      end
    end
  endfunction

  // Timeline model: each transaction is described by the edge it was
  // accepted on, the edge done was observed and the edge the result appeared.
  int                   e = 0;
  bit                   m_idle = 1'b1;
  int                   t_acc = -1, t_done = -1, t_res = -1;
  bit                   m_err = 1'b0;
  logic [IW-1:0]        m_class = '0;
  logic signed [DW-1:0] m_score = '0;
  int                   exp_idx;
  bit                   exp_v;

  always @(posedge clk) begin
    e++;
    if (!rst) begin
      m_idle = 1'b1; t_acc = -1; t_done = -1; t_res = -1;
      m_err = 1'b0; m_class = '0; m_score = '0;
    end else if (m_idle) begin
      if (req_valid) begin
        m_idle = 1'b0; t_acc = e; t_done = -1; t_res = -1; m_err = 1'b0;
      end
    end else if (t_res < 0) begin
      if (t_done < 0 && e >= t_acc + 3 && eng_done) begin
        t_done = e;
`ifdef INFER_TIMEOUT_EN
      end else if (t_done < 0 && e == t_acc + 2 + TO) begin
        t_res = e; m_err = 1'b1; m_class = '0; m_score = '0;
`endif
      end else if (t_done >= 0 && e == t_done + NC) begin
        t_res = e;
        argmax(m_class, m_score);
      end
    end else if (res_ready) begin
      m_idle = 1'b1; t_res = -1; t_done = -1;
    end

    #3;
    if (!rst) begin
      check("rst_eng_reset", eng_reset, 1'b0);
      check("rst_eng_start", eng_start, 1'b0);
      check("rst_eng_out_idx", eng_out_idx, 0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_res_class", res_class, 0);
      check("rst_res_score", $signed(res_score), 0);
      check("rst_busy", busy, 1'b0);
      check("rst_err_timeout", err_timeout, 1'b0);
    end else begin
      exp_idx = (t_done >= 0 && t_res < 0) ? e - t_done : 0;
      exp_v   = !m_idle && t_res >= 0;
      check("req_ready", req_ready, m_idle);
      check("busy", busy, !m_idle);
      check("eng_reset", eng_reset, !m_idle && e == t_acc);
      check("eng_start", eng_start, !m_idle && e == t_acc + 1);
      check("eng_out_idx", eng_out_idx, exp_idx);
      check("res_valid", res_valid, exp_v);
      if (exp_v) begin
        check("res_class", res_class, m_class);
        check("res_score", $signed(res_score), m_score);
      end
      check("err_timeout", err_timeout, m_err);
    end
  end

  task automatic load(input int v [NC]);
    for (int i = 0; i < NC; i++) scores[i] = DW'(v[i]);
  endtask

  task automatic start_req();
    int k = 0;
    @(negedge clk); req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    while (!eng_reset && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("eng_reset_pulse", eng_reset, 1'b1);
    eng_done = 1'b0;
    @(negedge clk);
    check("eng_start_pulse", eng_start, 1'b1);
    check("eng_reset_single", eng_reset, 1'b0);
  endtask

  task automatic finish_req(input int hold, input bit poke, input logic [IW-1:0] xc,
                            input logic signed [DW-1:0] xs, input bit xerr);
    int k = 0;
    while (!res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("res_valid_seen", res_valid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      req_valid = poke && (i == hold / 2);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("res_class_lit", res_class, xc);
    check("res_score_lit", $signed(res_score), xs);
    check("err_timeout_lit", err_timeout, xerr);
    check("res_valid_held", res_valid, 1'b1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_after_hs", res_valid, 1'b0);
    check("req_ready_after_hs", req_ready, 1'b1);
  endtask

  initial begin
    int v [NC];
    int k;
    for (int i = 0; i < NC; i++) scores[i] = '0;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("lit_rst_res_valid", res_valid, 1'b0);
    check("lit_rst_busy", busy, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("lit_idle_req_ready", req_ready, 1'b1);
    check("lit_idle_busy", busy, 1'b0);
    repeat (3) @(negedge clk);

    // Basic classify, done 20 cycles after start
    v = '{-5, 3, 12, -128, 7, 0, 11, 2, -1, 4};
    load(v);
    start_req();
    repeat (20) @(negedge clk);
    eng_done = 1'b1;
    finish_req(0, 1'b0, 4'd2, 8'sd12, 1'b0);

    // Tie between idx4 and idx8 keeps idx4
    v = '{-7, -7, -7, -7, -3, -7, -7, -7, -3, -7};
    load(v);
    start_req();
    repeat (4) @(negedge clk);
    eng_done = 1'b1;
    finish_req(0, 1'b0, 4'd4, -8'sd3, 1'b0);

    // All most-negative: class 0
    for (int i = 0; i < NC; i++) v[i] = -128;
    load(v);
    start_req();
    repeat (2) @(negedge clk);
    eng_done = 1'b1;
    finish_req(0, 1'b0, 4'd0, -8'sd128, 1'b0);

    // Backpressure with a request poked during RESULT; max at last index
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    load(v);
    start_req();
    repeat (3) @(negedge clk);
    eng_done = 1'b1;
    finish_req(15, 1'b1, 4'd9, 8'sd10, 1'b0);

    // Second request right away, done already present on the first WAIT cycle
    v = '{0, 0, 0, 0, 0, 0, 127, 0, 126, 0};
    load(v);
    start_req();
    eng_done = 1'b1;
    finish_req(0, 1'b0, 4'd6, 8'sd127, 1'b0);

    // Mid-run reset during SCAN at idx 5
    v = '{-5, 3, 12, -128, 7, 0, 11, 2, -1, 4};
    load(v);
    start_req();
    repeat (5) @(negedge clk);
    eng_done = 1'b1;
    k = 0;
    while (eng_out_idx != 4'd5 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("scan_reached_idx5", eng_out_idx, 5);
    rst = 1'b0;
    #1;
    check("async_rst_idx", eng_out_idx, 0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_res_class", res_class, 0);
    check("async_rst_res_score", $signed(res_score), 0);
    check("async_rst_res_valid", res_valid, 1'b0);
    eng_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_req();
    repeat (7) @(negedge clk);
    eng_done = 1'b1;
    finish_req(0, 1'b0, 4'd2, 8'sd12, 1'b0);

`ifdef INFER_TIMEOUT_EN
    // Watchdog: done never arrives
    start_req();
    finish_req(0, 1'b0, 4'd0, 8'sd0, 1'b1);
    start_req();
    check("err_cleared_on_accept", err_timeout, 1'b0);
    repeat (3) @(negedge clk);
    eng_done = 1'b1;
    finish_req(0, 1'b0, 4'd2, 8'sd12, 1'b0);
`else
    // No watchdog: WAIT holds indefinitely
    start_req();
    repeat (150) @(negedge clk);
    check("wait_hold_res_valid", res_valid, 1'b0);
    check("wait_hold_busy", busy, 1'b1);
    check("wait_hold_err", err_timeout, 1'b0);
    eng_done = 1'b1;
    finish_req(0, 1'b0, 4'd2, 8'sd12, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

endmodule
